// File: rtl/countdown_pkg.sv
`default_nettype none
// ============================================================================
// Module   : countdown_pkg
// Brief    : Shared state encoding and default width for countdown_timer.
//            Optional build macro: COUNTDOWN_AUTO_RELOAD_EN (used by the top).
// Revision : 1.0 - initial release
// ============================================================================
package countdown_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/countdown_core.sv
`default_nettype none
// ============================================================================
// Module   : countdown_core
// Brief    : Count register with load/decrement/hold muxing and q==1 detect.
// Revision : 1.0 - initial release
// ============================================================================
module countdown_core import countdown_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q_is_one
);

  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_zero = '0;

  logic [WIDTH-1:0] r_q;

  // Load wins over decrement; the decrement is suppressed at zero so q never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= c_zero;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_dec && (r_q != c_zero)) begin
      r_q <= r_q - c_one;
    end
  end

  assign o_q        = r_q;
  assign o_q_is_one = (r_q == c_one);

endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer
// Brief    : Loadable down counter with one-cycle terminal-count pulse.
//            Define COUNTDOWN_AUTO_RELOAD_EN for periodic auto-reload mode.
// Revision : 1.0 - initial release
// ============================================================================
module countdown_timer import countdown_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc
);

  state_t           r_state;
  logic             r_busy;
  logic             r_tc;
  logic             w_load;
  logic             w_dec;
  logic             w_q_is_one;
  logic             w_lv_nonzero;
  logic [WIDTH-1:0] w_q;

  assign w_lv_nonzero = (load_val != '0);

  always_comb begin
    w_load = 1'b0;
    w_dec  = 1'b0;
    case (r_state)
      RUN: begin
        if (abort) begin
          w_load = 1'b0;
        end else if (start) begin
          w_load = 1'b1;
        end else if (en) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          if (w_q_is_one && w_lv_nonzero) begin
            w_load = 1'b1;
          end else begin
            w_dec = 1'b1;
          end
`else
          w_dec = 1'b1;
`endif
        end
      end
      default: w_load = start;
    endcase
  end

  countdown_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_dec      (w_dec),
    .i_load_val (load_val),
    .o_q        (w_q),
    .o_q_is_one (w_q_is_one)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_tc    <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_tc    <= 1'b0;
          end else if (start) begin
            r_state <= w_lv_nonzero ? RUN : DONE;
            r_busy  <= w_lv_nonzero;
            r_tc    <= !w_lv_nonzero;
          end else if (en && w_q_is_one) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            // Reload keeps running and pulses tc; a zero preset ends normally.
            r_state <= w_lv_nonzero ? RUN : DONE;
            r_busy  <= w_lv_nonzero;
            r_tc    <= 1'b1;
`else
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_tc    <= 1'b1;
`endif
          end else begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_tc    <= 1'b0;
          end
        end
        default: begin
          // IDLE and DONE both accept a new start; abort has no effect here.
          if (start) begin
            r_state <= w_lv_nonzero ? RUN : DONE;
            r_busy  <= w_lv_nonzero;
            r_tc    <= !w_lv_nonzero;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_tc    <= 1'b0;
          end
        end
      endcase
    end
  end

  assign q    = w_q;
  assign busy = r_busy;
  assign tc   = r_tc;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_timer
// Brief    : Self-checking bench for countdown_timer against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] load_val;
  logic         en;
  logic         abort;
  logic [W-1:0] q;
  logic         busy;
  logic         tc;

  int checks;
  int failures;

  // Behavioural model: remaining count, running flag, pending pulse.
  int m_q;
  bit m_busy;
  bit m_tc;

  countdown_timer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .load_val (load_val),
    .en       (en),
    .abort    (abort),
    .q        (q),
    .busy     (busy),
    .tc       (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      $error("check %s", tag);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q"},    int'(q),    m_q);
    check({tag, ".busy"}, int'(busy), int'(m_busy));
    check({tag, ".tc"},   int'(tc),   int'(m_tc));
  endtask

  task automatic model_load(input int lv);
    m_q = lv;
    if (lv == 0) begin
      m_busy = 1'b0;
      m_tc   = 1'b1;
    end else begin
      m_busy = 1'b1;
    end
  endtask

  task automatic model_step(input bit st, input int lv, input bit e, input bit ab);
    m_tc = 1'b0;
    if (m_busy) begin
      if (ab) begin
        m_busy = 1'b0;
      end else if (st) begin
        model_load(lv);
      end else if (e) begin
        if (m_q == 1) begin
          m_tc = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          if (lv != 0) m_q = lv;
          else begin m_q = 0; m_busy = 1'b0; end
`else
          m_q = 0;
          m_busy = 1'b0;
`endif
        end else begin
          m_q = m_q - 1;
        end
      end
    end else if (st) begin
      model_load(lv);
    end
  endtask

  // Apply inputs away from the edge, clock once, then compare just after the edge.
  task automatic cycle(input bit st, input int lv, input bit e, input bit ab, input string tag);
    start    = st;
    load_val = W'(lv);
    en       = e;
    abort    = ab;
    @(posedge clk);
    model_step(st, lv, e, ab);
    #1;
    check_all(tag);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_q = 0; m_busy = 1'b0; m_tc = 1'b0;
    rst = 1'b0; start = 1'b0; load_val = '0; en = 1'b0; abort = 1'b0;

    @(posedge clk); #1;
    check_all("reset");
    rst = 1'b1;
    cycle(0, 0, 1, 0, "idle0");
    cycle(0, 7, 1, 0, "idle1");

    // Asynchronous reset in the middle of a count
    cycle(1, 9, 1, 0, "rstmid.load");
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, "rstmid.run");
    #2 rst = 1'b0;
    m_q = 0; m_busy = 1'b0; m_tc = 1'b0;
    #1 check_all("rstmid.async");
    @(posedge clk); #1;
    check_all("rstmid.held");
    rst = 1'b1;
    for (int i = 0; i < 2; i++) cycle(0, 3, 1, 0, "rstmid.after");

    // One-shot count of 5
    cycle(1, 5, 1, 0, "oneshot.load");
    for (int i = 0; i < 7; i++) cycle(0, 0, 1, 0, "oneshot.run");

    // Enable gaps
    cycle(1, 3, 1, 0, "gaps.load");
    cycle(0, 0, 1, 0, "gaps.e1");
    cycle(0, 0, 0, 0, "gaps.e0a");
    cycle(0, 0, 0, 0, "gaps.e0b");
    cycle(0, 0, 1, 0, "gaps.e1b");
    cycle(0, 0, 1, 0, "gaps.e1c");
    cycle(0, 0, 1, 0, "gaps.idle");

    // Zero-length count
    cycle(1, 0, 1, 0, "zero.load");
    cycle(0, 0, 1, 1, "zero.abortdone");
    cycle(0, 0, 1, 0, "zero.idle");

    // Maximum preset, no wrap
    cycle(1, 15, 1, 0, "max.load");
    for (int i = 0; i < 17; i++) cycle(0, 0, 1, 0, "max.run");

    // Abort at q=5
    cycle(1, 8, 1, 0, "abort.load");
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, "abort.run");
    cycle(0, 0, 1, 1, "abort.hit");
    cycle(0, 0, 1, 0, "abort.idle");

    // Restart at q=6 with preset 2
    cycle(1, 8, 1, 0, "restart.load");
    for (int i = 0; i < 2; i++) cycle(0, 0, 1, 0, "restart.run");
    cycle(1, 2, 1, 0, "restart.hit");
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, "restart.tail");

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    cycle(1, 4, 1, 0, "reload.load");
    for (int i = 0; i < 12; i++) cycle(0, 4, 1, 0, "reload.run");
    cycle(0, 4, 1, 1, "reload.abort");
    cycle(0, 4, 1, 0, "reload.idle");
`endif

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(7) == 0), int'($urandom_range(15)),
            ($urandom_range(3) != 0), ($urandom_range(23) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
